// File: rtl/vga_pixel_compositor.sv
// Per-pixel colour compositor: layer priority, background fill, frame-aligned
// night-mode inversion and frame-counted flashing, two-stage registered output.
module vga_pixel_compositor #(
  parameter int NUM_LAYERS   = 4,
  parameter int RED_W        = 3,
  parameter int GRN_W        = 3,
  parameter int BLU_W        = 2,
  localparam int COLOR_W     = RED_W + GRN_W + BLU_W,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int FLASH_FRAMES = 15,
  parameter logic [NUM_LAYERS-1:0] FLASH_MASK = {NUM_LAYERS{1'b1}}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [X_W-1:0]                vgaX,
  input  logic [Y_W-1:0]                vgaY,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [NUM_LAYERS-1:0]         layer_hit,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic [COLOR_W-1:0]            bg_color,
  input  logic                          invert_req,
  input  logic                          flash_en,
  output logic [RED_W-1:0]              vgaRed,
  output logic [GRN_W-1:0]              vgaGreen,
  output logic [BLU_W-1:0]              vgaBlue,
  output logic                          Hsync,
  output logic                          Vsync,
  output logic                          night_mode,
  output logic                          frame_start
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  logic [COLOR_W-1:0] w_col_on;
  logic [COLOR_W-1:0] w_col_off;
  logic               w_visible;
  logic               w_origin;

  logic [COLOR_W-1:0] r_s1_col_on;
  logic [COLOR_W-1:0] r_s1_col_off;
  logic               r_s1_vis;
  logic               r_s1_hs;
  logic               r_s1_vs;
  logic               r_frame_start;

  logic               r_night_mode;
  logic               r_pending;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_flash_off;

  logic               w_night_nxt;
  logic               w_pend_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_off_nxt;
  logic [COLOR_W-1:0] w_sel;
  logic [COLOR_W-1:0] w_pix;

  logic [RED_W-1:0]   r_red;
  logic [GRN_W-1:0]   r_grn;
  logic [BLU_W-1:0]   r_blu;
  logic               r_hs;
  logic               r_vs;

  assign w_visible = (vgaX < X_W'(SCREEN_W)) && (vgaY < Y_W'(SCREEN_H));
  assign w_origin  = (vgaX == '0) && (vgaY == '0);

  // Both winners are resolved up front; stage 2 picks one once the flash phase
  // for that pixel is known, so (0,0) already sees a phase change.
  always_comb begin
    w_col_on  = bg_color;
    w_col_off = bg_color;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      w_col_on  = layer_hit[i] ? layer_color[i*COLOR_W +: COLOR_W] : w_col_on;
      w_col_off = (layer_hit[i] && !FLASH_MASK[i]) ?
                  layer_color[i*COLOR_W +: COLOR_W] : w_col_off;
    end
  end

  // Next-state for night mode and its pending request
  always_comb begin
    w_night_nxt = r_night_mode;
    w_pend_nxt  = r_pending;
    if (r_frame_start) begin
      if (r_pending || invert_req) begin
        w_night_nxt = ~r_night_mode;
      end else begin
        w_night_nxt = r_night_mode;
      end
      w_pend_nxt = 1'b0;
    end else if (invert_req) begin
      w_pend_nxt = 1'b1;
    end else begin
      w_pend_nxt = r_pending;
    end
  end

  // Next-state for flash frame counter and phase
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_off_nxt = r_flash_off;
    if (!flash_en) begin
      w_cnt_nxt = '0;
      w_off_nxt = 1'b0;
    end else if (r_frame_start) begin
      if (r_cnt == CNT_W'(FLASH_FRAMES - 1)) begin
        w_cnt_nxt = '0;
        w_off_nxt = ~r_flash_off;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_off_nxt = r_flash_off;
      end
    end else begin
      w_cnt_nxt = r_cnt;
      w_off_nxt = r_flash_off;
    end
  end

  // Stage 2 uses next-state mode bits so a change takes effect from pixel (0,0)
  always_comb begin
    w_sel = w_off_nxt ? r_s1_col_off : r_s1_col_on;
    if (!r_s1_vis) begin
      w_pix = '0;
    end else if (w_night_nxt) begin
      w_pix = ~w_sel;
    end else begin
      w_pix = w_sel;
    end
  end

  // Stage 1 pipeline register and frame_start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_col_on   <= '0;
      r_s1_col_off  <= '0;
      r_s1_vis      <= 1'b0;
      r_s1_hs       <= 1'b1;
      r_s1_vs       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_s1_col_on   <= w_col_on;
      r_s1_col_off  <= w_col_off;
      r_s1_vis      <= w_visible;
      r_s1_hs       <= hsync_in;
      r_s1_vs       <= vsync_in;
      r_frame_start <= w_origin;
    end
  end

  // Night-mode and flash state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_night_mode <= 1'b0;
      r_pending    <= 1'b0;
      r_cnt        <= '0;
      r_flash_off  <= 1'b0;
    end else begin
      r_night_mode <= w_night_nxt;
      r_pending    <= w_pend_nxt;
      r_cnt        <= w_cnt_nxt;
      r_flash_off  <= w_off_nxt;
    end
  end

  // Stage 2 output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_red <= w_pix[COLOR_W-1 -: RED_W];
      r_grn <= w_pix[GRN_W+BLU_W-1 -: GRN_W];
      r_blu <= w_pix[BLU_W-1:0];
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
    end
  end

  assign vgaRed      = r_red;
  assign vgaGreen    = r_grn;
  assign vgaBlue     = r_blu;
  assign Hsync       = r_hs;
  assign Vsync       = r_vs;
  assign night_mode  = r_night_mode;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pixel_compositor.sv
// Scoreboard bench for vga_pixel_compositor using short synthetic frames
// (each frame begins when the scan coordinates return to (0,0)).
module tb_vga_pixel_compositor;

  localparam int          FF    = 2;
  localparam logic [3:0]  FMASK = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  vgaX;
  logic [8:0]  vgaY;
  logic        hsync_in, vsync_in;
  logic [3:0]  layer_hit;
  logic [31:0] layer_color;
  logic [7:0]  bg_color;
  logic        invert_req, flash_en;
  logic [2:0]  vgaRed, vgaGreen;
  logic [1:0]  vgaBlue;
  logic        Hsync, Vsync, night_mode, frame_start;

  always #5 clk = ~clk;

  vga_pixel_compositor #(
    .NUM_LAYERS(4), .RED_W(3), .GRN_W(3), .BLU_W(2),
    .SCREEN_W(640), .SCREEN_H(480), .X_W(10), .Y_W(9),
    .FLASH_FRAMES(FF), .FLASH_MASK(FMASK)
  ) dut (
    .clk(clk), .rst(rst), .vgaX(vgaX), .vgaY(vgaY),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .layer_hit(layer_hit), .layer_color(layer_color), .bg_color(bg_color),
    .invert_req(invert_req), .flash_en(flash_en),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .Hsync(Hsync), .Vsync(Vsync), .night_mode(night_mode), .frame_start(frame_start)
  );

  int n_vec = 0;
  int n_err = 0;
  int hs_low = 0;
  logic [9:0] sb_q[$];

  // reference model state
  logic       m_night, m_pend, m_off, m_fs;
  int         m_cnt;
  logic [7:0] m_on, m_offc;
  logic       m_vis, m_hs, m_vs;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_night = 1'b0; m_pend = 1'b0; m_off = 1'b0; m_fs = 1'b0; m_cnt = 0;
    m_on = 8'h00; m_offc = 8'h00; m_vis = 1'b0; m_hs = 1'b1; m_vs = 1'b1;
  endtask

  // Drive one pixel for one clock, predict and check the pixel leaving stage 2.
  task automatic step(input logic [9:0] x, input logic [8:0] y,
                      input logic [3:0] hit, input logic inv);
    logic       nn, np, no, got_on, got_off;
    int         nc;
    logic [7:0] pix, won, woff;
    logic [9:0] exp;
    vgaX = x; vgaY = y; layer_hit = hit; invert_req = inv;
    nn = m_night; np = m_pend; no = m_off; nc = m_cnt;
    if (m_fs) begin
      if (m_pend || inv) nn = ~m_night;
      np = 1'b0;
    end else if (inv) np = 1'b1;
    if (!flash_en) begin
      nc = 0; no = 1'b0;
    end else if (m_fs) begin
      if (m_cnt == FF - 1) begin nc = 0; no = ~m_off; end
      else nc = m_cnt + 1;
    end
    pix = no ? m_offc : m_on;
    if (nn) pix = ~pix;
    if (!m_vis) pix = 8'h00;
    sb_q.push_back({pix, m_hs, m_vs});
    won = bg_color; woff = bg_color; got_on = 1'b0; got_off = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (hit[i] && !got_on) begin won = layer_color[i*8 +: 8]; got_on = 1'b1; end
      if (hit[i] && !FMASK[i] && !got_off) begin woff = layer_color[i*8 +: 8]; got_off = 1'b1; end
    end
    m_on = won; m_offc = woff;
    m_vis = (x < 10'd640) && (y < 9'd480);
    m_hs = hsync_in; m_vs = vsync_in;
    m_night = nn; m_pend = np; m_off = no; m_cnt = nc;
    m_fs = (x == 10'd0) && (y == 9'd0);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    check_val("rgb", {vgaRed, vgaGreen, vgaBlue}, exp[9:2]);
    check_val("hsync", Hsync, exp[1]);
    check_val("vsync", Vsync, exp[0]);
    check_val("night_mode", night_mode, m_night);
    check_val("frame_start", frame_start, m_fs);
    if (!Hsync) hs_low++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rgb"}, {vgaRed, vgaGreen, vgaBlue}, 8'h00);
    check_val({tag, "_hs"}, Hsync, 1'b1);
    check_val({tag, "_vs"}, Vsync, 1'b1);
    check_val({tag, "_night"}, night_mode, 1'b0);
    check_val({tag, "_fs"}, frame_start, 1'b0);
  endtask

  logic flash_on_exp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; vgaX = 10'd5; vgaY = 9'd5; hsync_in = 1'b1; vsync_in = 1'b1;
    layer_hit = 4'b0000; layer_color = 32'h0; bg_color = 8'h00;
    invert_req = 1'b0; flash_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // priority: layer1 beats layer2; no hit falls back to background
    layer_color = {8'h55, 8'h1C, 8'hE0, 8'h03};
    bg_color = 8'hFF;
    step(10'd100, 9'd100, 4'b0110, 1'b0);
    step(10'd101, 9'd100, 4'b0000, 1'b0);
    check_val("prio_red", vgaRed, 3'b111);
    check_val("prio_green", vgaGreen, 3'b000);
    check_val("prio_blue", vgaBlue, 2'b00);
    step(10'd102, 9'd100, 4'b0000, 1'b0);
    check_val("bg_all_ones", {vgaRed, vgaGreen, vgaBlue}, 8'hFF);

    // blanking region outputs zero even with a hit
    step(10'd640, 9'd100, 4'b0001, 1'b0);
    step(10'd641, 9'd100, 4'b0000, 1'b0);
    check_val("blank_zero", {vgaRed, vgaGreen, vgaBlue}, 8'h00);

    // 96-cycle hsync pulse survives the pipeline intact
    hs_low = 0;
    hsync_in = 1'b0;
    for (int i = 0; i < 96; i++) step(10'(200 + i), 9'd10, 4'b0001, 1'b0);
    hsync_in = 1'b1;
    for (int i = 0; i < 4; i++) step(10'(300 + i), 9'd10, 4'b0001, 1'b0);
    check_val("hsync_low_len", hs_low, 96);

    // mid-frame request waits for the frame boundary
    step(10'd50, 9'd10, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) step(10'(51 + i), 9'd10, 4'b0000, 1'b0);
    check_val("night_waits", night_mode, 1'b0);
    step(10'd0, 9'd0, 4'b0000, 1'b0);
    step(10'd1, 9'd0, 4'b0000, 1'b0);
    check_val("night_toggled", night_mode, 1'b1);
    check_val("night_origin_inv", {vgaRed, vgaGreen, vgaBlue}, 8'h00);

    // three requests in one frame give one toggle
    step(10'd20, 9'd5, 4'b0000, 1'b1);
    step(10'd21, 9'd5, 4'b0000, 1'b0);
    step(10'd22, 9'd5, 4'b0000, 1'b1);
    step(10'd23, 9'd5, 4'b0000, 1'b1);
    step(10'd24, 9'd5, 4'b0000, 1'b0);
    step(10'd0, 9'd0, 4'b0000, 1'b0);
    step(10'd1, 9'd0, 4'b0000, 1'b0);
    check_val("three_pulses_one", night_mode, 1'b0);
    step(10'd2, 9'd0, 4'b0000, 1'b0);
    step(10'd0, 9'd0, 4'b0000, 1'b0);
    step(10'd1, 9'd0, 4'b0000, 1'b0);
    check_val("no_extra_toggle", night_mode, 1'b0);

    // request coincident with frame_start inverts pixel (0,0)
    step(10'd10, 9'd10, 4'b0000, 1'b0);
    step(10'd0, 9'd0, 4'b0000, 1'b0);
    step(10'd1, 9'd0, 4'b0000, 1'b1);
    check_val("simul_night", night_mode, 1'b1);
    check_val("simul_origin_inv", {vgaRed, vgaGreen, vgaBlue}, 8'h00);
    step(10'd0, 9'd0, 4'b0000, 1'b0);
    step(10'd1, 9'd0, 4'b0000, 1'b1);
    check_val("night_back_off", night_mode, 1'b0);

    // flash: layer0 masked on off phases, layer1 never
    layer_color = {8'h55, 8'h22, 8'h1C, 8'hE0};
    bg_color = 8'h03;
    step(10'd5, 9'd5, 4'b0000, 1'b0);
    flash_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      step(10'd0, 9'd0, 4'b0000, 1'b0);
      step(10'd1, 9'd0, 4'b0000, 1'b0);
      step(10'd10, 9'd10, 4'b0001, 1'b0);
      step(10'd11, 9'd10, 4'b0010, 1'b0);
      check_val("flash_layer0", {vgaRed, vgaGreen, vgaBlue},
                flash_on_exp[f] ? 8'hE0 : 8'h03);
      step(10'd12, 9'd10, 4'b0001, 1'b0);
      check_val("flash_layer1", {vgaRed, vgaGreen, vgaBlue}, 8'h1C);
    end
    flash_en = 1'b0;
    step(10'd13, 9'd10, 4'b0001, 1'b0);
    step(10'd14, 9'd10, 4'b0000, 1'b0);
    check_val("flash_disable", {vgaRed, vgaGreen, vgaBlue}, 8'hE0);

    // build night=1, pending=1, flash_off=1, then reset mid-frame
    flash_en = 1'b1;
    step(10'd0, 9'd0, 4'b0000, 1'b0);
    step(10'd1, 9'd0, 4'b0000, 1'b1);
    step(10'd0, 9'd0, 4'b0000, 1'b0);
    step(10'd1, 9'd0, 4'b0000, 1'b0);
    hsync_in = 1'b0; vsync_in = 1'b0;
    step(10'd30, 9'd30, 4'b0001, 1'b1);
    step(10'd31, 9'd30, 4'b0001, 1'b0);
    check_val("pre_rst_night", night_mode, 1'b1);
    check_val("pre_rst_hs", Hsync, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    model_reset();
    sb_q.delete();
    step(10'd32, 9'd30, 4'b0000, 1'b0);
    step(10'd0, 9'd0, 4'b0000, 1'b0);
    step(10'd1, 9'd0, 4'b0000, 1'b0);
    check_val("rst_no_toggle", night_mode, 1'b0);
    step(10'd10, 9'd10, 4'b0001, 1'b0);
    step(10'd11, 9'd10, 4'b0000, 1'b0);
    check_val("rst_flash_cleared", {vgaRed, vgaGreen, vgaBlue}, 8'hE0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_pixel_compositor.md
# vga_pixel_compositor

Parametrised per-pixel colour compositor between the sprite delegates and the VGA pins. Takes NUM_LAYERS hit flags and per-layer colours, resolves priority, and fills the background. Adds frame-synchronised night-mode inversion and frame-counted layer flashing. Emits registered RGB with sync delayed to match, on one clock.

## Interface
- NUM_LAYERS, 4: number of sprite layers; layer 0 has highest priority.
- RED_W, 3 / GRN_W, 3 / BLU_W, 2: channel widths; COLOR_W = RED_W+GRN_W+BLU_W; colour word packed {R,G,B}.
- SCREEN_W, 640 / SCREEN_H, 480: visible area.
- X_W, 10 / Y_W, 9: scan coordinate widths.
- FLASH_FRAMES, 15: frames per flash phase; must be ≥1.
- FLASH_MASK, {NUM_LAYERS{1'b1}}: layers suppressed during flash off-phase.

Ports:
- clk  in  1  pixel clock (one clock domain).
- rst  in  1  synchronous, active-high reset.
- vgaX  in  X_W  current scan X.
- vgaY  in  Y_W  current scan Y.
- hsync_in / vsync_in  in  1 each  raw syncs aligned with vgaX/vgaY.
- layer_hit  in  NUM_LAYERS  per-layer pixel-covered flag.
- layer_color  in  NUM_LAYERS*COLOR_W  layer i colour at bits [i*COLOR_W +: COLOR_W].
- bg_color  in  COLOR_W  background colour.
- invert_req  in  1  single-cycle pulse requesting a night-mode toggle.
- flash_en  in  1  level; enables flashing.
- vgaRed / vgaGreen / vgaBlue  out  RED_W / GRN_W / BLU_W  registered colour.
- Hsync / Vsync  out  1 each  registered, delayed sync.
- night_mode  out  1  current inversion state.
- frame_start  out  1  one-cycle pulse, registered.

## Operation
- Visible pixel: vgaX < SCREEN_W && vgaY < SCREEN_H. Non-visible pixels output all-zero colour, with no inversion applied.
- Priority:
  - Effective hit = layer_hit[i] && !(flash_off && FLASH_MASK[i]).
  - Lowest-index effective hit supplies the colour.
  - No effective hit → bg_color.
- Stage 1 (registered):
  - Inputs: winning colour, visible flag, hsync_in, vsync_in.
  - frame_start <= (vgaX==0 && vgaY==0).
- Stage 2 (registered):
  - Output colour = visible ? (night_mode ? ~colour : colour) : 0.
  - Syncs are passed through.
- Night mode:
  - invert_req sets a pending flag.
  - On a frame_start cycle: if pending or invert_req is high, night_mode toggles and pending clears.
  - Further invert_req pulses while pending are absorbed: one toggle per frame maximum.
  - night_mode changes only at frame boundaries, so no tearing.
- Flash:
  - flash_en low: frame counter=0 and flash_off=0, synchronously.
  - flash_en high: counter increments on each frame_start. When counter reaches FLASH_FRAMES-1 and frame_start fires, counter wraps to 0 and flash_off toggles.
  - Counter width: $clog2(FLASH_FRAMES+1).

## Timing
- Latency: colour and syncs both exactly 2 clk from inputs to outputs; sync/colour alignment preserved.
- frame_start: asserted 1 clk after the (0,0) input cycle, i.e. concurrent with the stage-1 data of that pixel.
- Timing of night_mode and flash_off changes:
  - Both update on the clock edge that ends a frame_start cycle.
  - The new value affects stage 2 from the next cycle. The first pixel (0,0) of the frame uses the new value.
- Reset values:
  - vgaRed/Green/Blue = 0; Hsync = Vsync = 1.
  - night_mode = 0, pending = 0, frame_start = 0, counter = 0, flash_off = 0.
  - Pipeline valid data reappears 2 clk after rst deasserts.
- Reset mid-frame: all state clears immediately, with no partial toggle; pending requests are lost.
- Simultaneous invert_req and frame_start: the toggle applies at that frame_start.
- flash_en dropping mid-phase: flash_off clears on the next edge. This is not frame-aligned, by design, for instant restore.

## Test plan
- Priority: layer_hit=4'b0110, layer1=8'hE0, layer2=8'h1C, pixel (100,100) → 2 clk later RGB = 3'b111/3'b000/2'b00; layer_hit=0 with bg=8'hFF → all ones.
- Blanking and sync alignment:
  - vgaX=640 with layer0 hit → output 0.
  - hsync_in low for 96 cycles → Hsync low for exactly 96 cycles, starting 2 clk later, aligned with colour.
- Night mode:
  - invert_req pulse mid-frame → night_mode stays 0 until the next (0,0). Then bg 8'hFF outputs 0.
  - Three pulses within one frame → exactly one toggle.
- Simultaneous events: invert_req in the same cycle as frame_start → night_mode toggles on that edge, and pixel (0,0) is inverted.
- Flash with FLASH_FRAMES=2, FLASH_MASK=4'b0001, flash_en=1:
  - Layer 0 is visible for 2 frames, suppressed for 2 frames (bg shown), and so on. Layer 1 is never suppressed.
  - flash_en low → immediately visible.
- Reset mid-frame with night_mode=1, pending=1, flash_off=1 → next cycle all reset values hold; Hsync=Vsync=1; no toggle at the following frame_start.
